// File: rtl/bit_serial_adder.sv
// Bit-serial adder: a single full adder steps through WIDTH-bit operands
// LSB first, with the carry registered between bits and valid/ready on both sides.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] xs, ys;
    logic [WIDTH-1:0] s_shift;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last;
    logic             fa_sum, fa_cout;

    assign last = (count == CW'(WIDTH - 1));

    full_adder u_fa (
        .a   (xs[0]),
        .b   (ys[0]),
        .ci  (carry),
        .sum (fa_sum),
        .co  (fa_cout)
    );

    // Each new sum bit enters at the MSB so that after WIDTH steps bit 0 sits at s[0].
    if (WIDTH == 1) begin : g_w1
        assign s_shift = fa_sum;
    end else begin : g_wn
        assign s_shift = {fa_sum, s[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = BUSY;
            end
            BUSY: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs    <= '0;
            ys    <= '0;
            carry <= 1'b0;
            count <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xs    <= x;
                        ys    <= y;
                        carry <= cin;
                        count <= '0;
                    end
                end
                BUSY: begin
                    s     <= s_shift;
                    carry <= fa_cout;
                    xs    <= xs >> 1;
                    ys    <= ys >> 1;
                    count <= count + CW'(1);
                    if (last) cout <= fa_cout;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: three instances (WIDTH 8, 1, 32) checked every
// cycle against a transaction-level model, plus directed literal results.

module tb_bit_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid  [3];
    logic        out_ready [3];
    logic        cin       [3];
    logic [31:0] x         [3];
    logic [31:0] y         [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        cout_w    [3];
    logic [31:0] s_w       [3];

    logic [7:0]  s8;
    logic [0:0]  s1;
    logic [31:0] s32;
    assign s_w[0] = {24'b0, s8};
    assign s_w[1] = {31'b0, s1};
    assign s_w[2] = s32;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x[0][7:0]), .y(y[0][7:0]), .cin(cin[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .s(s8), .cout(cout_w[0])
    );
    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x[1][0:0]), .y(y[1][0:0]), .cin(cin[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .s(s1), .cout(cout_w[1])
    );
    bit_serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x[2]), .y(y[2]), .cin(cin[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .s(s32), .cout(cout_w[2])
    );

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int wid(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 1 : 32);
    endfunction

    // {cout,s} is simply the (WIDTH+1)-bit truncation of x + y + cin.
    function automatic longint model_sum(input int d, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
        longint m;
        m = (longint'(1) << wid(d)) - 1;
        return ((longint'(a) & m) + (longint'(b) & m) + longint'(c)) & ((m << 1) | 1);
    endfunction

    function automatic longint dut_result(input int d);
        return (longint'(cout_w[d]) << wid(d)) | longint'(s_w[d]);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: an accepted request must show up as a valid result
    // exactly WIDTH edges later, then hold until taken.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
    mphase_t ph     [3];
    longint  exp_r  [3];
    int      due    [3];

    initial for (int d = 0; d < 3; d++) ph[d] = M_IDLE;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                ph[d] = M_IDLE;
            end else begin
                if (ph[d] == M_BUSY && cyc == due[d]) ph[d] = M_DONE;
                case (ph[d])
                    M_IDLE: begin
                        check($sformatf("idle_in_ready[%0d]", d), in_ready[d], 1);
                        check($sformatf("idle_out_valid[%0d]", d), out_valid[d], 0);
                        if (in_valid[d]) begin
                            exp_r[d] = model_sum(d, x[d], y[d], cin[d]);
                            due[d]   = cyc + 1 + wid(d);
                            ph[d]    = M_BUSY;
                        end
                    end
                    M_BUSY: begin
                        check($sformatf("busy_in_ready[%0d]", d), in_ready[d], 0);
                        check($sformatf("busy_out_valid[%0d]", d), out_valid[d], 0);
                    end
                    M_DONE: begin
                        check($sformatf("done_in_ready[%0d]", d), in_ready[d], 0);
                        check($sformatf("done_out_valid[%0d]", d), out_valid[d], 1);
                        check($sformatf("done_result[%0d]", d), dut_result(d), exp_r[d]);
                        if (out_ready[d]) ph[d] = M_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // One request/response transaction; lat counts edges from acceptance to out_valid.
    task automatic run_op(input int d, input logic [31:0] xv, input logic [31:0] yv,
                          input logic ci, input int stall, input bit scramble,
                          output longint res, output int lat);
        int n;
        res = -1;
        lat = -1;
        @(posedge clk); #1;
        x[d] = xv; y[d] = yv; cin[d] = ci; in_valid[d] = 1'b1;
        n = 0;
        while (!in_ready[d] && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready[d]) begin
            check($sformatf("accept_timeout[%0d]", d), in_ready[d], 1);
            in_valid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        n = 0;
        while (!out_valid[d] && n < 100) begin
            if (scramble) begin
                x[d] = $urandom; y[d] = $urandom;
                cin[d] = 1'($urandom); in_valid[d] = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid[d] = 1'b0;
        if (!out_valid[d]) begin
            check($sformatf("result_timeout[%0d]", d), out_valid[d], 1);
            return;
        end
        lat = n;
        res = dut_result(d);
        repeat (stall) begin @(posedge clk); #1; end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint res;
        int     lat;

        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; cin[d] = 1'b0;
            x[d] = '0; y[d] = '0;
        end

        // Reset values are visible before the first clock edge.
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_in_ready[%0d]", d), in_ready[d], 1);
            check($sformatf("rst_out_valid[%0d]", d), out_valid[d], 0);
            check($sformatf("rst_s[%0d]", d), s_w[d], 0);
            check($sformatf("rst_cout[%0d]", d), cout_w[d], 0);
        end
        @(negedge clk); #2 rst = 1'b0;

        // FF + 01: full carry ripple, result in exactly 8 edges.
        run_op(0, 32'hFF, 32'h01, 1'b0, 0, 1'b0, res, lat);
        check("ff_plus_01_latency", lat, 8);
        check("ff_plus_01_result", res, 64'h100);

        // A5 + 5A + 1 under 5 cycles of backpressure.
        run_op(0, 32'hA5, 32'h5A, 1'b1, 5, 1'b0, res, lat);
        check("a5_5a_c1_result", res, 64'h100);
        check("a5_5a_c1_held_s", s_w[0], 0);
        check("a5_5a_c1_held_cout", cout_w[0], 1);

        // Inputs churn during BUSY; result reflects the latched operands.
        run_op(0, 32'h12, 32'h34, 1'b1, 2, 1'b1, res, lat);
        check("scramble_latency", lat, 8);
        check("scramble_result", res, 64'h047);

        // Reset on the 4th BUSY edge aborts the operation.
        @(posedge clk); #1;
        x[0] = 32'hF0; y[0] = 32'h0F; cin[0] = 1'b1; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("abort_accepted", in_ready[0], 0);
        repeat (3) @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready[0], 1);
        check("abort_out_valid", out_valid[0], 0);
        check("abort_s", s_w[0], 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid[0], 0);
        end
        run_op(0, 32'd3, 32'd4, 1'b0, 0, 1'b0, res, lat);
        check("after_abort_latency", lat, 8);
        check("after_abort_result", res, 64'h007);

        // Random traffic on the 1-bit and 32-bit instances in parallel.
        fork
            begin
                longint r1;
                int     l1;
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    run_op(1, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3),
                           1'($urandom), r1, l1);
                    check("w1_latency", l1, 1);
                end
            end
            begin
                longint r32;
                int     l32;
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    run_op(2, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3),
                           1'($urandom), r32, l32);
                    check("w32_latency", l32, 32);
                end
            end
        join

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
